// File: rtl/muldiv_if.sv
// Pipeline-side bundle for the multiply/divide unit.
// The execute/decode stages drive the master side; muldiv_unit sits on the slave side.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_w;
  logic             lo_w;
  logic [WIDTH-1:0] wdata;
  logic             rd_hilo;
  logic             flush;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, a, b, hi_w, lo_w, wdata, rd_hilo, flush,
    input  busy, done, stall, hi_out, lo_out
  );

  modport slave (
    input  start, op, a, b, hi_w, lo_w, wdata, rd_hilo, flush,
    output busy, done, stall, hi_out, lo_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO registers.
// Operands are reduced to magnitudes on accept, processed unsigned
// (shift-add multiply or restoring divide over one shared 2*WIDTH
// accumulator), and sign-corrected in FIX.
// Optional build macro: MULDIV_FAST_MUL_EN -- single-cycle combinational
// MULT/MULTU; division stays iterative.
//
// state | meaning
// IDLE  | waiting; services MTHI/MTLO
// MUL   | one shift-add step per cycle
// DIV   | one restoring-divide step per cycle
// FIX   | sign correction, HI/LO write
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic      clk,
  input logic      reset,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [CNT_W-1:0]   cnt;
  logic               is_div, neg_res, neg_rem, div0;
  logic [WIDTH-1:0]   hi, lo;
  logic               done_q;

  logic               accept, signed_op, sign_a, sign_b, last_step;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix;

  // A flush in the request cycle cancels the request outright.
  assign accept    = (state == IDLE) && bus.start && !bus.flush;
  assign signed_op = !bus.op[0];
  assign sign_a    = signed_op && bus.a[WIDTH-1];
  assign sign_b    = signed_op && bus.b[WIDTH-1];
  assign abs_a     = sign_a ? -bus.a : bus.a;
  assign abs_b     = sign_b ? -bus.b : bus.b;
  assign last_step = (cnt == CNT_W'(WIDTH-1));

  // Iteration datapath: acc holds {partial, multiplier} or {remainder, quotient}.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd};

  // With a zero divisor the restoring loop leaves rem=|a|, so re-signing
  // it reproduces the original dividend; only LO needs forcing.
  assign prod_fix = neg_res ? -acc : acc;
  assign quo      = acc[WIDTH-1:0];
  assign rem      = acc[2*WIDTH-1:WIDTH];
  assign quo_fix  = div0 ? '1 : (neg_res ? -quo : quo);
  assign rem_fix  = neg_rem ? -rem : rem;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_a, fast_b, fast_prod;
  assign fast_a    = {{WIDTH{sign_a}}, bus.a};
  assign fast_b    = {{WIDTH{sign_b}}, bus.b};
  assign fast_prod = fast_a * fast_b;
`endif

  assign bus.busy   = (state != IDLE);
  assign bus.stall  = bus.busy && (bus.start || bus.rd_hilo || bus.hi_w || bus.lo_w);
  assign bus.done   = done_q;
  assign bus.hi_out = hi;
  assign bus.lo_out = lo;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.op[1]) state_nxt = DIV;
`ifdef MULDIV_FAST_MUL_EN
          else           state_nxt = IDLE;
`else
          else           state_nxt = MUL;
`endif
        end
      end
      MUL:     if (last_step) state_nxt = FIX;
      DIV:     if (last_step) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  // Operand capture, iteration steps, HI/LO writes and the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      opnd    <= '0;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt     <= '0;
            is_div  <= bus.op[1];
            neg_res <= sign_a ^ sign_b;
            neg_rem <= sign_a;
            div0    <= (bus.b == '0);
            if (bus.op[1]) begin
              acc  <= {{WIDTH{1'b0}}, abs_a};
              opnd <= abs_b;
            end else begin
              acc  <= {{WIDTH{1'b0}}, abs_b};
              opnd <= abs_a;
            end
`ifdef MULDIV_FAST_MUL_EN
            if (!bus.op[1]) begin
              hi     <= fast_prod[2*WIDTH-1:WIDTH];
              lo     <= fast_prod[WIDTH-1:0];
              done_q <= 1'b1;
            end
`endif
          end else if (!bus.start && !bus.flush) begin
            if (bus.hi_w) hi <= bus.wdata;
            if (bus.lo_w) lo <= bus.wdata;
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
        DIV: begin
          if (!div_diff[WIDTH]) acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          else                  acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (!bus.flush) begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops
// compared against an arithmetic reference model.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, p, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin u = {32'b0, a} * {32'b0, b}; hi = u[63:32]; lo = u[31:0]; end
      default: begin
        if (b == 0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else if (op == 2'b10) begin
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0];
        end else begin
          lo = a / b; hi = a % b;
        end
      end
    endcase
  endfunction

  task automatic write_hilo(input logic h, input logic l, input logic [31:0] d);
    @(negedge clk);
    bus.hi_w = h; bus.lo_w = l; bus.wdata = d;
    @(negedge clk);
    bus.hi_w = 1'b0; bus.lo_w = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] eh, el;
    int n, bc, elat;
    model(op, a, b, eh, el);
    issue(op, a, b);
    n  = 0;
    bc = bus.busy ? 1 : 0;
    while (!bus.done && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (bus.busy) bc++;
    end
    elat = (FAST && !op[1]) ? 0 : 33;
    chk({tag, "_latency"}, 64'(n), 64'(elat));
    chk({tag, "_busy_cycles"}, 64'(bc), 64'(elat));
    chk({tag, "_hi"}, 64'(bus.hi_out), 64'(eh));
    chk({tag, "_lo"}, 64'(bus.lo_out), 64'(el));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'(0));
  endtask

  initial begin
    logic [31:0] eh, el, a, b;
    logic [1:0]  op;
    int n, dn;

    reset = 1'b1;
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
    bus.hi_w = 0; bus.lo_w = 0; bus.wdata = 0; bus.rd_hilo = 0; bus.flush = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_stall", 64'(bus.stall), 64'(0));
    chk("rst_hi", 64'(bus.hi_out), 64'(0));
    chk("rst_lo", 64'(bus.lo_out), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    // Directed cases.
    run_op(2'b00, 32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, "divu_m7_2");
    run_op(2'b11, 32'h0000_1234, 32'd0, "divu_by0");
    run_op(2'b10, 32'hFFFF_FF00, 32'd0, "div_neg_by0");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");

    // MTHI/MTLO, both at once and separately.
    write_hilo(1'b1, 1'b1, 32'h5A5A_0001);
    #1;
    chk("mt_both_hi", 64'(bus.hi_out), 64'h5A5A_0001);
    chk("mt_both_lo", 64'(bus.lo_out), 64'h5A5A_0001);

    // Stall while a divide runs; MTHI and MFHI must be held off.
    model(2'b10, 32'd1000, 32'hFFFF_FFF9, eh, el);
    issue(2'b10, 32'd1000, 32'hFFFF_FFF9);
    bus.rd_hilo = 1'b1; bus.hi_w = 1'b1; bus.wdata = 32'hAA;
    #0;
    n = 0;
    while (bus.busy && n < 100) begin
      chk("stall_busy", 64'(bus.stall), 64'(1));
      @(posedge clk); #1;
      n++;
    end
    chk("stall_span", 64'(n), 64'(33));
    chk("stall_done", 64'(bus.done), 64'(1));
    chk("stall_release", 64'(bus.stall), 64'(0));
    chk("stall_hi", 64'(bus.hi_out), 64'(eh));
    chk("stall_lo", 64'(bus.lo_out), 64'(el));
    bus.hi_w = 1'b0; bus.rd_hilo = 1'b0;

    // Flush mid-operation keeps HI/LO and suppresses done.
    write_hilo(1'b1, 1'b0, 32'h11);
    write_hilo(1'b0, 1'b1, 32'h22);
    issue(FAST ? 2'b11 : 2'b01, 32'd5, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'(0));
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) dn++;
      @(posedge clk); #1;
    end
    chk("flush_no_done", 64'(dn), 64'(0));
    chk("flush_hi", 64'(bus.hi_out), 64'h11);
    chk("flush_lo", 64'(bus.lo_out), 64'h22);

    // Start together with flush is ignored entirely.
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b00; bus.a = 32'd9; bus.b = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("startflush_busy", 64'(bus.busy), 64'(0));
    @(posedge clk); #1;
    chk("startflush_done", 64'(bus.done), 64'(0));
    chk("startflush_lo", 64'(bus.lo_out), 64'h22);

    // Async reset mid-divide.
    issue(2'b10, 32'h7654_3210, 32'd13);
    repeat (14) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'(0));
    chk("midrst_hi", 64'(bus.hi_out), 64'(0));
    chk("midrst_lo", 64'(bus.lo_out), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    run_op(2'b10, 32'h7654_3210, 32'd13, "post_rst_div");

    // Random operations.
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 255));
      run_op(op, a, b, $sformatf("rnd%0d_op%0d", i, op));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers for the MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU from the execute stage and runs an iterative shift-add multiplier or a restoring divider.
- Services MTHI/MTLO writes and MFHI/MFLO reads.
- Raises a stall while the pipeline would otherwise consume stale HI/LO or issue a second operation.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold WIDTH+1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  execute stage presents a mul/div op this cycle
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  WIDTH  rs operand (dividend / multiplicand)
- b  in  WIDTH  rt operand (divisor / multiplier)
- hi_w  in  1  MTHI write
- lo_w  in  1  MTLO write
- wdata  in  WIDTH  MTHI/MTLO data
- rd_hilo  in  1  decode stage issuing MFHI/MFLO
- flush  in  1  pipeline flush; aborts the in-flight op
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when HI/LO are updated by an op
- stall  out  1  hold the pipeline
- hi_out  out  WIDTH  registered HI
- lo_out  out  WIDTH  registered LO

Behaviour:
- Reset (async): state=IDLE, HI=LO=0, cnt=0, busy=done=stall=0.
- States: IDLE, MUL, DIV, FIX.
- stall = busy & (start | rd_hilo | hi_w | lo_w). It is combinational. Any start/hi_w/lo_w sampled while stall=1 is ignored; the pipeline re-presents it.
- IDLE + start: latch |a|, |b| (signed ops) or raw (unsigned); latch result signs; cnt=0.
  - MULT/MULTU -> MUL.
  - DIV/DIVU -> DIV.
- IDLE + start + hi_w/lo_w in the same cycle: start has priority; the writes are dropped.
- IDLE, no start: hi_w loads HI<=wdata and lo_w loads LO<=wdata on the same edge; both may be set together.
- MUL: one shift-add step per cycle over a 2*WIDTH accumulator; after WIDTH steps (cnt==WIDTH-1) -> FIX.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit); after WIDTH steps -> FIX.
- FIX: apply sign correction, write HI/LO on the exiting edge, done=1 for the following cycle, -> IDLE.
  - MUL: negate the 64-bit product if the operand signs differ; HI=upper half, LO=lower half.
  - DIV: LO=quotient, truncated toward zero; HI=remainder, with the sign of the dividend.
- busy=1 in MUL, DIV and FIX.
- Latency: accept edge T0.
  - Iterative mul: HI/LO written at edge T0+WIDTH+1 (33 for WIDTH=32).
  - Div: HI/LO written at edge T0+WIDTH+1.
  - busy high for WIDTH+1 cycles.
- Divide by zero: no trap. LO=all-ones, HI=a (original operand), for signed and unsigned alike; it still takes the full latency.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- flush: in MUL/DIV/FIX, return to IDLE next edge with HI/LO unchanged and no done pulse. flush together with start in IDLE: start is ignored. flush has priority over every other input.
- hi_out/lo_out always show the register contents. The pipeline must not read them while stall=1.
- Reset asserted mid-operation: immediate IDLE, HI=LO=0.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU complete in one cycle using a combinational WIDTH x WIDTH product.
  - HI/LO are written on the accept edge and done pulses the next cycle.
  - busy stays 0; state MUL is unused.
  - A flush in the accept cycle suppresses the write.
- Not defined: iterative multiply as specified above. Division is iterative in both builds.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA, done 33 cycles after accept (1 cycle with MULDIV_FAST_MUL_EN).
- DIV a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU same operands -> LO=0x7FFFFFFC, HI=1; busy high exactly 33 cycles.
- DIVU a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x1234; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- During DIV busy, assert rd_hilo and hi_w=1 wdata=0xAA -> stall=1 every cycle until FIX completes; HI ends as the div result, not 0xAA; rd_hilo after done reads the result.
- Start MULTU 5x7, assert flush on cycle 10 -> IDLE next edge, HI/LO keep prior values (0x11/0x22 loaded via MTHI/MTLO), no done pulse.
- Assert reset mid-DIV at cycle 15 -> busy=0, HI=LO=0 immediately (async); next start proceeds normally.
